// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input vectors of a 3-input logic stage, holds each SETTLE+1 cycles, and captures its truth table.
// The port named `table` in the interface is called `tbl` because `table` is a reserved word. Macro TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN selects Gray-code sweep order.
module truth_table_sweeper #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] tbl,
  output logic       match
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic [2:0] cur_vec;
  logic [2:0] next_vec;
  logic [7:0] tbl_next;

  function automatic logic [2:0] vec_of(input logic [2:0] n);
`ifdef TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

  always_comb begin
    cur_vec           = vec_of(idx);
    next_vec          = vec_of(idx + 3'd1);
    tbl_next          = tbl;
    tbl_next[cur_vec] = dut_out;
  end

  // Outputs are registered on entry to each state, so match is computed against
  // the table including the final sample and is already valid while done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in1   <= 1'b0;
      in2   <= 1'b0;
      in3   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tbl   <= 8'h00;
      match <= 1'b0;
      cnt   <= 8'd0;
      idx   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= APPLY;
            idx             <= 3'd0;
            cnt             <= 8'd0;
            tbl             <= 8'h00;
            match           <= 1'b0;
            busy            <= 1'b1;
            {in1, in2, in3} <= vec_of(3'd0);
          end
        end
        APPLY: begin
          cnt <= cnt + 8'd1;
          if (cnt == SETTLE_M1) state <= SAMPLE;
        end
        SAMPLE: begin
          tbl <= tbl_next;
          if (idx == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            match <= (tbl_next == expected);
          end else begin
            state           <= APPLY;
            idx             <= idx + 3'd1;
            cnt             <= 8'd0;
            {in1, in2, in3} <= next_vec;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: SETTLE=4 instance plus a SETTLE=1 instance.
module tb_truth_table_sweeper;

`ifdef TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN
  localparam logic [2:0] LAST_VEC  = 3'b100;
  localparam int         MULTI_EXP = 0;
  localparam logic [7:0] PART_TBL  = 8'h02;
`else
  localparam logic [2:0] LAST_VEC  = 3'b111;
  localparam int         MULTI_EXP = 3;
  localparam logic [7:0] PART_TBL  = 8'h06;
`endif

  logic       clk = 1'b0;
  logic       reset, start, start_f;
  logic [7:0] expected, expected_f;
  logic       dut_out, dut_out_f;
  logic       in1, in2, in3, busy, done, match;
  logic       f1, f2, f3, busy_f, done_f, match_f;
  logic [7:0] tbl, tbl_f;
  int         mode;

  int checks = 0;
  int errors = 0;

  int dcyc, dcount, bfirst, blast, bcnt, steps, multi;
  logic m_at_done;

  always #5 clk = ~clk;

  truth_table_sweeper u_dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .dut_out(dut_out),
    .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done), .tbl(tbl), .match(match)
  );

  truth_table_sweeper #(.SETTLE(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .expected(expected_f), .dut_out(dut_out_f),
    .in1(f1), .in2(f2), .in3(f3), .busy(busy_f), .done(done_f), .tbl(tbl_f), .match(match_f)
  );

  // Bench models of the logic stage under test.
  always_comb begin
    if (mode == 1) dut_out = in1 ^ in2 ^ in3;
    else           dut_out = ({in1, in2, in3} == 3'b100) || ({in1, in2, in3} == 3'b111);
    dut_out_f = f3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then observes 60 cycles; cycle 1 is the one after the edge that samples start.
  task automatic sweep(input int restart_at);
    logic [2:0] vprev;
    start = 1'b1;
    tick();
    start = 1'b0;
    dcyc = -1; dcount = 0; bfirst = -1; blast = -1; bcnt = 0;
    steps = 0; multi = 0; m_at_done = 1'bx; vprev = 3'd0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) begin
        bcnt++;
        if (bfirst < 0) bfirst = c;
        blast = c;
        if (c > 1 && {in1, in2, in3} != vprev) begin
          steps++;
          if ($countones({in1, in2, in3} ^ vprev) != 1) multi++;
        end
      end
      vprev = {in1, in2, in3};
      if (done) begin
        dcount++;
        if (dcyc < 0) begin
          dcyc = c;
          m_at_done = match;
        end
      end
      start = (c == restart_at) || (restart_at > 0 && done);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_f = 1'b0; expected = 8'h90; expected_f = 8'hAA; mode = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tbl", tbl, 8'h00);
    chk("rst_match", match, 0);
    chk("rst_vec", {in1, in2, in3}, 3'b000);

    // Basic sweep, matching expectation.
    sweep(0);
    chk("s1_done_cycle", dcyc, 41);
    chk("s1_done_count", dcount, 1);
    chk("s1_busy_first", bfirst, 1);
    chk("s1_busy_last", blast, 40);
    chk("s1_busy_count", bcnt, 40);
    chk("s1_match_at_done", m_at_done, 1);
    chk("s1_tbl", tbl, 8'h90);
    chk("s1_match", match, 1);
    chk("s1_idle_vec", {in1, in2, in3}, LAST_VEC);
    chk("s1_steps", steps, 7);
    chk("s1_multi_bit_steps", multi, MULTI_EXP);

    // expected is ignored outside the completion cycle.
    expected = 8'h00;
    tick(); tick(); tick();
    chk("hold_match", match, 1);
    chk("hold_tbl", tbl, 8'h90);

    // Mismatching expectation.
    expected = 8'h91;
    sweep(0);
    chk("s2_tbl", tbl, 8'h90);
    chk("s2_match", match, 0);
    chk("s2_done_cycle", dcyc, 41);

    // start re-pulsed mid-sweep and on the done cycle.
    expected = 8'h90;
    sweep(10);
    chk("s3_done_cycle", dcyc, 41);
    chk("s3_done_count", dcount, 1);
    chk("s3_busy_count", bcnt, 40);
    chk("s3_match", match, 1);

    // Reset in cycle 20 of a sweep.
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("rs_partial_tbl", tbl, PART_TBL);
    chk("rs_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_tbl", tbl, 8'h00);
    chk("rs_match", match, 0);
    chk("rs_vec", {in1, in2, in3}, 3'b000);
    dcount = 0;
    for (int c = 0; c < 50; c++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("rs_no_activity", dcount, 0);

    // Fresh sweep after reset, parity stage.
    expected = 8'h96;
    sweep(0);
    chk("x_tbl", tbl, 8'h96);
    chk("x_match", match, 1);
    chk("x_done_cycle", dcyc, 41);
    chk("x_multi_bit_steps", multi, MULTI_EXP);

    // SETTLE=1 instance, stage output = in3.
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    dcyc = -1;
    dcount = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done_f) begin
        dcount++;
        if (dcyc < 0) dcyc = c;
      end
      tick();
    end
    chk("f_done_cycle", dcyc, 17);
    chk("f_done_count", dcount, 1);
    chk("f_tbl", tbl_f, 8'hAA);
    chk("f_match", match_f, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE, default 4: cycles each input vector is held before the sample cycle; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a full 8-vector sweep.
REQ-005 SHALL have port expected, input, 8: reference truth table, bit k = required out for {in1,in2,in3}=k.
REQ-006 SHALL have port dut_out, input, 1: output of the 3-input logic stage under test.
REQ-007 SHALL have ports in1, in2, in3, output, 1 each: registered drive to the downstream logic stage; in1 is MSB of the vector.
REQ-008 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-009 SHALL have port done, output, 1: one-cycle pulse at sweep completion.
REQ-010 SHALL have port table, output, 8: captured truth table, bit k = sampled dut_out for vector k.
REQ-011 SHALL have port match, output, 1: table equals expected, valid from done onward.

Function
REQ-012 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE.
REQ-013 IDLE: start=1 -> APPLY; vector index 0; settle counter 0; table cleared to 8'h00; match cleared to 0.
REQ-014 APPLY: {in1,in2,in3} driven from current vector; counter increments each cycle; at counter=SETTLE-1 -> SAMPLE.
REQ-015 SAMPLE: table[vector value] <= dut_out; index 7 -> DONE, else index+1, counter 0, -> APPLY.
REQ-016 Each vector SHALL be held exactly SETTLE+1 cycles (SETTLE in APPLY, 1 in SAMPLE).
REQ-017 DONE: done=1 for exactly that cycle; match <= (table==expected), with table including the final sample; -> IDLE.
REQ-018 Latency: done high exactly 1+8*(SETTLE+1) cycles after the edge sampling start (41 for SETTLE=4).
REQ-019 busy SHALL be 1 in APPLY and SAMPLE, 0 in IDLE and DONE.
REQ-020 start while busy SHALL be ignored with no restart or extension.
REQ-021 start asserted during the DONE cycle SHALL be ignored; a new sweep begins only from IDLE.
REQ-022 table and match SHALL hold their values in IDLE until the next accepted start.
REQ-023 In IDLE and DONE, in1/in2/in3 SHALL hold the last applied vector; after reset they SHALL be 0.
REQ-024 expected SHALL be sampled only in DONE; changes at other times have no effect.

Reset
REQ-025 reset=1 SHALL, at the next edge: state IDLE; in1=in2=in3=0; busy=0; done=0; table=8'h00; match=0; counter=0; index=0.
REQ-026 reset mid-sweep SHALL abort with no done pulse; the partial table is discarded.
REQ-027 reset SHALL take priority over start in the same cycle.

Configuration
REQ-028 Macro TRUTH_TABLE_SWEEPER_GRAY_ORDER_EN defined: vector n of the sweep = n ^ (n>>1) (000,001,011,010,110,111,101,100), so exactly one input toggles per step; capture indexed by vector value, so table bit mapping is unchanged.
REQ-029 Macro undefined: vector n = n (binary order 000..111).
REQ-030 Latency, done, match and reset behaviour SHALL be identical with and without the macro.

Verification
REQ-031 SETTLE=4, bench DUT out=1 only for vectors 100 and 111, expected=8'h90, start pulse -> done at cycle 41, table=8'h90, match=1, busy high cycles 1..40.
REQ-032 Same DUT, expected=8'h91 -> table=8'h90, match=0.
REQ-033 start re-pulsed at cycle 10 and again on the done cycle -> single done at cycle 41; no second sweep starts.
REQ-034 reset at cycle 20 of a sweep -> next cycle idle outputs all 0, no done; a fresh start yields the correct table.
REQ-035 Macro defined, DUT = in1^in2^in3 -> table=8'h96; monitor confirms exactly one of in1/in2/in3 changes per vector step.
REQ-036 SETTLE=1, DUT out = in3 -> done at cycle 17, table=8'hAA.
